// File: rtl/cp0_reg_file.sv
// Coprocessor-0 register file: MFC0/MTC0 responder plus exception, ERET and interrupt state.
// Optional timer (Count/Compare/TI) is built only when CP0_TIMER_EN is defined.
module cp0_reg_file #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp0_write_en_i,
  input  logic        cp0_read_en_i,
  input  logic [7:0]  cp0_addr_i,
  input  logic [31:0] cp0_write_data_i,
  output logic [31:0] cp0_read_data_o,
  input  logic        exc_en_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_delayslot_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  input  logic [5:0]  hw_int_i,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        int_req_o
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  logic [4:0]  addr_rd;
  logic        addr_sel0;
  logic        wr_en;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        ti;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic [5:0]  ip_hw;

  assign addr_rd   = cp0_addr_i[7:3];
  assign addr_sel0 = (cp0_addr_i[2:0] == 3'd0);
  // An MTC0 only commits when no exception or ERET claims the same cycle.
  assign wr_en     = cp0_write_en_i & ~exc_en_i & ~eret_i & addr_sel0;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (exc_en_i) begin
      if (!exl_q) begin
        epc_d = exc_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        bd_d  = exc_delayslot_i;
      end
      exl_d      = 1'b1;
      exc_code_d = exc_code_i;
      if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) begin
        badvaddr_d = exc_badvaddr_i;
      end
    end else if (eret_i) begin
      exl_d = 1'b0;
    end else if (wr_en) begin
      case (addr_rd)
        RegStatus: begin
          im_d  = cp0_write_data_i[15:8];
          exl_d = cp0_write_data_i[1];
          ie_d  = cp0_write_data_i[0];
        end
        RegCause: ip_sw_d = cp0_write_data_i[9:8];
        RegEpc:   epc_d   = cp0_write_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= STATUS_RESET[15:8];
      exl_q      <= STATUS_RESET[1];
      ie_q       <= STATUS_RESET[0];
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;

  // Count advances on every second edge; compare match uses the pre-increment value.
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = tick_q ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
    if (wr_en && (addr_rd == RegCount)) begin
      count_d = cp0_write_data_i;
      tick_d  = 1'b0;
    end
    if (wr_en && (addr_rd == RegCompare)) begin
      compare_d = cp0_write_data_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign ti          = ti_q;
  assign count_val   = count_q;
  assign compare_val = compare_q;
`else
  assign ti          = 1'b0;
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
`endif

  assign ip_hw    = {hw_int_i[5] | ti, hw_int_i[4:0]};
  assign status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_o  = {bd_q, ti, 14'd0, ip_hw, ip_sw_q, 1'b0, exc_code_q, 2'b00};
  assign epc_o    = epc_q;
  assign int_req_o = ie_q & ~exl_q & (|(cause_o[15:8] & status_o[15:8]));

  always_comb begin
    cp0_read_data_o = 32'd0;
    if (cp0_read_en_i && addr_sel0) begin
      case (addr_rd)
        RegBadVAddr: cp0_read_data_o = badvaddr_q;
        RegCount:    cp0_read_data_o = count_val;
        RegCompare:  cp0_read_data_o = compare_val;
        RegStatus:   cp0_read_data_o = status_o;
        RegCause:    cp0_read_data_o = cause_o;
        RegEpc:      cp0_read_data_o = epc_q;
        default:     cp0_read_data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_reg_file.sv
// Scoreboard bench for cp0_reg_file; builds with or without CP0_TIMER_EN.
module tb_cp0_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cp0_write_en;
  logic        cp0_read_en;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_write_data;
  logic [31:0] cp0_read_data;
  logic        exc_en;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_delayslot;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic        int_req;

`ifdef CP0_TIMER_EN
  localparam logic [31:0] TiBits = 32'h4000_8000;
  localparam logic [31:0] TimerIrq = 32'd1;
`else
  localparam logic [31:0] TiBits = 32'h0000_0000;
  localparam logic [31:0] TimerIrq = 32'd0;
`endif

  localparam logic [7:0] ABadV = 8'h40;
  localparam logic [7:0] ACnt  = 8'h48;
  localparam logic [7:0] ACmp  = 8'h58;
  localparam logic [7:0] ASts  = 8'h60;
  localparam logic [7:0] ACau  = 8'h68;
  localparam logic [7:0] AEpc  = 8'h70;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  cp0_reg_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cp0_write_en_i   (cp0_write_en),
    .cp0_read_en_i    (cp0_read_en),
    .cp0_addr_i       (cp0_addr),
    .cp0_write_data_i (cp0_write_data),
    .cp0_read_data_o  (cp0_read_data),
    .exc_en_i         (exc_en),
    .exc_code_i       (exc_code),
    .exc_pc_i         (exc_pc),
    .exc_delayslot_i  (exc_delayslot),
    .exc_badvaddr_i   (exc_badvaddr),
    .eret_i           (eret),
    .hw_int_i         (hw_int),
    .epc_o            (epc),
    .status_o         (status),
    .cause_o          (cause),
    .int_req_o        (int_req)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input logic [7:0] addr, input logic en,
                           input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    cp0_addr    = addr;
    cp0_read_en = en;
    #1;
    check_val(tag_q.pop_front(), cp0_read_data, exp_q.pop_front());
    cp0_read_en = 1'b0;
  endtask

  // which: 0 int_req, 1 epc, 2 status, 3 cause
  task automatic expect_port(input string tag, input int which, input logic [31:0] exp);
    logic [31:0] obs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    case (which)
      0:       obs = {31'd0, int_req};
      1:       obs = epc;
      2:       obs = status;
      default: obs = cause;
    endcase
    check_val(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cp0_write_en = 1'b0;
    exc_en       = 1'b0;
    eret         = 1'b0;
  endtask

  task automatic set_wr(input logic [7:0] addr, input logic [31:0] data);
    cp0_write_en   = 1'b1;
    cp0_addr       = addr;
    cp0_write_data = data;
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bva);
    exc_en        = 1'b1;
    exc_code      = code;
    exc_pc        = pc;
    exc_delayslot = ds;
    exc_badvaddr  = bva;
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    set_wr(addr, data);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cp0_write_en = 1'b0; cp0_read_en = 1'b0; cp0_addr = 8'd0; cp0_write_data = 32'd0;
    exc_en = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_delayslot = 1'b0;
    exc_badvaddr = 32'd0; eret = 1'b0; hw_int = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    expect_rd("rst_status", ASts, 1'b1, 32'h0040_0000);
    expect_rd("rst_cause", ACau, 1'b1, 32'h0);
    expect_port("rst_int_req", 0, 32'd0);
    expect_rd("rst_epc", AEpc, 1'b1, 32'h0);
    expect_rd("rd_disabled", ASts, 1'b0, 32'h0);

    mtc0(ASts, 32'hFFFF_FFFF);
    expect_rd("status_all_ones", ASts, 1'b1, 32'h0040_FF03);
    hw_int = 6'b000001;
    expect_rd("cause_hw0", ACau, 1'b1, 32'h0000_0400 | TiBits);
    expect_port("int_req_exl", 0, 32'd0);
    mtc0(ASts, 32'h0000_0401);
    expect_port("status_port", 2, 32'h0040_0401);
    expect_port("int_req_on", 0, 32'd1);

    mtc0(ABadV, 32'hDEAD_BEEF);
    expect_rd("badv_ro", ABadV, 1'b1, 32'h0);
    mtc0(8'h38, 32'h0000_1234);
    expect_rd("unimpl_rd", 8'h38, 1'b1, 32'h0);
    expect_rd("sel_nonzero", 8'h61, 1'b1, 32'h0);
    mtc0(AEpc, 32'h1357_2468);
    expect_rd("epc_write", AEpc, 1'b1, 32'h1357_2468);

    set_exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h1234_5671);
    cycle();
    expect_rd("exc1_epc", AEpc, 1'b1, 32'hBFC0_00FC);
    expect_rd("exc1_cause", ACau, 1'b1, 32'h8000_0410 | TiBits);
    expect_rd("exc1_badv", ABadV, 1'b1, 32'h1234_5671);
    expect_port("exc1_status", 2, 32'h0040_0403);
    expect_port("exc1_int_req", 0, 32'd0);

    set_exc(5'd8, 32'h0000_0200, 1'b0, 32'hFFFF_0000);
    cycle();
    expect_port("exc2_epc", 1, 32'hBFC0_00FC);
    expect_port("exc2_cause", 3, 32'h8000_0420 | TiBits);
    expect_rd("exc2_badv", ABadV, 1'b1, 32'h1234_5671);

    eret = 1'b1;
    set_wr(AEpc, 32'h0000_0077);
    cycle();
    expect_port("eret_epc_kept", 1, 32'hBFC0_00FC);
    expect_port("eret_status", 2, 32'h0040_0401);
    expect_port("eret_int_req", 0, 32'd1);

    set_exc(5'd5, 32'h0000_1000, 1'b0, 32'hCAFE_BABC);
    eret = 1'b1;
    set_wr(AEpc, 32'h5555_5555);
    cycle();
    expect_rd("combo_epc", AEpc, 1'b1, 32'h0000_1000);
    expect_port("combo_status", 2, 32'h0040_0403);
    expect_port("combo_cause", 3, 32'h0000_0414 | TiBits);
    expect_rd("combo_badv", ABadV, 1'b1, 32'hCAFE_BABC);
    eret = 1'b1;
    cycle();
    expect_port("eret2_status", 2, 32'h0040_0401);

    set_exc(5'd12, 32'h0000_0000, 1'b1, 32'h0);
    cycle();
    expect_port("wrap_epc", 1, 32'hFFFF_FFFC);
    expect_port("wrap_cause", 3, 32'h8000_0430 | TiBits);
    eret = 1'b1;
    cycle();

    mtc0(ACau, 32'hFFFF_FFFF);
    expect_rd("cause_write", ACau, 1'b1, 32'h8000_0730 | TiBits);
    hw_int = 6'd0;
    mtc0(ACau, 32'h0);
    expect_rd("cause_clear", ACau, 1'b1, 32'h8000_0030 | TiBits);
    mtc0(ASts, 32'h0000_8001);
    expect_port("ip7_int_req", 0, TimerIrq);

`ifdef CP0_TIMER_EN
    mtc0(ACmp, 32'd3);
    expect_rd("cmp_clear_ti", ACau, 1'b1, 32'h8000_0030);
    expect_rd("cmp_read", ACmp, 1'b1, 32'd3);
    mtc0(ACnt, 32'd0);
    expect_rd("cnt_loaded", ACnt, 1'b1, 32'd0);
    repeat (6) cycle();
    expect_rd("cnt_at_3", ACnt, 1'b1, 32'd3);
    expect_rd("ti_not_yet", ACau, 1'b1, 32'h8000_0030);
    cycle();
    expect_rd("ti_set", ACau, 1'b1, 32'hC000_8030);
    expect_port("ti_int_req", 0, 32'd1);
    mtc0(ACmp, 32'd100);
    expect_rd("ti_cleared", ACau, 1'b1, 32'h8000_0030);
    expect_port("ti_int_req_off", 0, 32'd0);
`else
    mtc0(ACnt, 32'd5);
    repeat (10) cycle();
    expect_rd("no_timer_cnt", ACnt, 1'b1, 32'd0);
    expect_rd("no_timer_cmp", ACmp, 1'b1, 32'd0);
    expect_rd("no_timer_ti", ACau, 1'b1, 32'h8000_0030);
`endif

    #3 rst_n = 1'b0;
    expect_port("async_rst_status", 2, 32'h0040_0000);
    expect_port("async_rst_epc", 1, 32'h0);
    expect_port("async_rst_cause", 3, 32'h0);
    expect_port("async_rst_int_req", 0, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_rd("post_rst_badv", ABadV, 1'b1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_reg_file.md
# cp0_reg_file

Coprocessor-0 register file: the responder for the CP0 read/write requests generated in decode, plus the exception/ERET/interrupt logic that owns Status, Cause, EPC, BadVAddr, Count and Compare. Sits beside the writeback stage; MFC0 reads are combinational for the pipeline's register-write path, MTC0 writes and exception updates commit on the clock edge. Produces the pipeline interrupt request and EPC for ERET redirection.

## Interface
- `STATUS_RESET`, 32'h0040_0000, Status reset value (BEV=1).
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cp0_write_en`  in  1  MTC0 commit this cycle
- `cp0_read_en`  in  1  MFC0 read this cycle
- `cp0_addr`  in  8  {rd[4:0], sel[2:0]}
- `cp0_write_data`  in  32  MTC0 data
- `cp0_read_data`  out  32  MFC0 result; 0 when `cp0_read_en`=0
- `exc_en`  in  1  exception committed this cycle
- `exc_code`  in  5  ExcCode of the exception
- `exc_pc`  in  32  PC of the faulting instruction
- `exc_delayslot`  in  1  faulting instruction is in a delay slot
- `exc_badvaddr`  in  32  faulting address (AdEL/AdES)
- `eret`  in  1  ERET committed this cycle
- `hw_int`  in  6  external interrupt lines, level-sensitive
- `epc`  out  32  current EPC
- `status`  out  32  current Status
- `cause`  out  32  current Cause
- `int_req`  out  1  interrupt pending and enabled

## Operation
- Implemented addresses (sel=0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Other addresses read 0; writes ignored.
- Status: writable IM[15:8], EXL[1], IE[0]; BEV[22] constant 1; other bits read 0.
- Cause: BD[31], TI[30], IP[15:10] = {hw_int[5] | TI, hw_int[4:0]} sampled each cycle, IP[9:8] writable, ExcCode[6:2]; other bits 0.
- EPC, Compare: fully writable. BadVAddr: read-only to MTC0. Count: fully writable.
- Priority per cycle: `exc_en` > `eret` > `cp0_write_en`. A write coinciding with exc_en or eret is discarded.
- Exception: if EXL=0: EPC <= exc_delayslot ? exc_pc-4 : exc_pc (32-bit wrap), BD <= exc_delayslot. Always: EXL <= 1, ExcCode <= exc_code. If exc_code is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr.
- ERET: EXL <= 0; nothing else changes.
- `int_req` = IE & ~EXL & |(Cause[15:8] & Status[15:8]), combinational from registered state and current hw_int.
- Read mux combinational from current registered values; no bypass of a same-cycle write.

## Timing
- Reset (async on rst_n low): Status=STATUS_RESET, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0; hence int_req=0, cp0_read_data=0.
- Write/exception/ERET effects visible on outputs the cycle after the edge.
- Count: 1-bit tick toggles every cycle; Count += 1 (mod 2^32) on edges where tick=1. MTC0 to Count loads data and clears tick; next increment two edges later.
- TI: set on an edge where Count==Compare (pre-increment value) and no Compare write; sticky; cleared by MTC0 to Compare (clear wins over same-cycle set).
- Reset mid-operation overrides everything immediately; no partial updates.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare/tick/TI implemented as above.
- Undefined: Count and Compare read 0, writes ignored, TI and Cause[30] constant 0, IP7 = hw_int[5] only; no timer state flops.

## Test plan
- Reset then MFC0 addr {12,0} -> 32'h0040_0000; addr {13,0} -> 0; int_req=0.
- MTC0 Status=32'hFFFF_FFFF -> reads 32'h0040_FF03; hw_int=6'b000001 -> int_req=1 (IE=1, EXL=1? no: EXL set, so 0); then MTC0 Status=32'h0000_0401 -> int_req=1.
- exc_en, exc_code=4, exc_pc=32'hBFC0_0100, exc_delayslot=1, badvaddr=32'h1234_5671 -> EPC=32'hBFC0_00FC, BD=1, ExcCode=4, BadVAddr=32'h1234_5671, EXL=1; second exception code 8 -> EPC unchanged, ExcCode=8.
- exc_en and eret and MTC0 EPC in same cycle -> exception applied, EXL=1, EPC from exc_pc, write dropped; then eret alone -> EXL=0.
- CP0_TIMER_EN: MTC0 Count=0, Compare=3 -> Count reaches 3 after 6 edges, TI=1, IP7 set; MTC0 Compare=100 -> TI=0 next cycle.
- Without CP0_TIMER_EN: MTC0 Count=5 -> MFC0 Count=0 after 10 cycles; TI stays 0.
